// File: rtl/sys_array_feeder_pkg.sv
// Shared types and sizing helpers for the systolic array feeder.
package sys_array_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } feeder_state_t;

  function automatic int rows_f(input int meshRows, input int tileRows);
    return meshRows * tileRows;
  endfunction

  function automatic int cols_f(input int meshColumns, input int tileColumns);
    return meshColumns * tileColumns;
  endfunction

  // Bubbles needed so the last beat reaches the far corner of the mesh.
  function automatic int flush_cycles_f(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sys_array_feeder_if.sv
// Upstream beat bus of the feeder: valid/ready handshake plus A, B, D vectors.
interface sys_array_feeder_if #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int BITWIDTH = 8
) ();

  logic                     up_valid;
  logic                     up_ready;
  logic                     up_last;
  logic [ROWS*BITWIDTH-1:0] up_a;
  logic [COLS*BITWIDTH-1:0] up_b;
  logic [COLS*BITWIDTH-1:0] up_d;

  modport master (
    output up_valid, up_last, up_a, up_b, up_d,
    input  up_ready
  );

  modport slave (
    input  up_valid, up_last, up_a, up_b, up_d,
    output up_ready
  );

endinterface

// File: rtl/sys_array_feeder_skew_delay_line.sv
// Fixed-depth shift register used to skew one mesh lane by its position.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  // Shift the lane one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sys_array_feeder.sv
// Feeder front end: accepts aligned beats, tags them with dataflow/propagate,
// skews each lane by mesh position and flushes the mesh after every job.
module sys_array_feeder
  import sys_array_pkg::*;
#(
  parameter int MESHROWS    = 4,
  parameter int MESHCOLUMNS = 4,
  parameter int TILEROWS    = 1,
  parameter int TILECOLUMNS = 1,
  parameter int BITWIDTH    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_dataflow,
  sys_array_feeder_if.slave       up,
  output logic [MESHROWS-1:0][TILEROWS-1:0][BITWIDTH-1:0]       out_a,
  output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0][BITWIDTH-1:0] out_b,
  output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0][BITWIDTH-1:0] out_d,
  output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0]               out_dataflow,
  output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0]               out_propagate,
  output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0]               out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int ROWS         = rows_f(MESHROWS, TILEROWS);
  localparam int COLS         = cols_f(MESHCOLUMNS, TILECOLUMNS);
  localparam int FLUSH_CYCLES = flush_cycles_f(ROWS, COLS);
  localparam int RCW          = $clog2(ROWS) + 1;
  localparam int FCW          = $clog2(FLUSH_CYCLES) + 1;
  localparam int CW           = 2 * BITWIDTH + 3;

  feeder_state_t  state_q, state_d;
  logic [FCW-1:0] flushCnt_q;
  logic [RCW-1:0] rowCnt_q;
  logic           flag_q;
  logic           dataflow_q;
  logic           ready;
  logic           accept;
  logic           issueDataflow;
  logic           flushLast;

  assign flushLast  = (flushCnt_q == FCW'(FLUSH_CYCLES - 1));
  assign accept     = up.up_valid & ready;
  assign up.up_ready = ready;
  assign busy       = (state_q != IDLE);

  // Next-state, handshake readiness and the end-of-flush pulse.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (up.up_valid) state_d = up.up_last ? FLUSH : STREAM;
      end
      STREAM: begin
        ready = 1'b1;
        if (up.up_valid && up.up_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (flushLast) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Count bubbles while flushing; idle at zero otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flushCnt_q <= '0;
    end else if (state_q == FLUSH) begin
      flushCnt_q <= flushLast ? '0 : flushCnt_q + FCW'(1);
    end else begin
      flushCnt_q <= '0;
    end
  end

  // Dataflow is captured only by the first beat of a job.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) dataflow_q <= 1'b0;
    else if (accept && state_q == IDLE) dataflow_q <= cfg_dataflow;
  end

  // Propagate flips after every full matrix and after the last beat of a job.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rowCnt_q <= '0;
      flag_q   <= 1'b0;
    end else if (accept) begin
      if (up.up_last || rowCnt_q == RCW'(ROWS - 1)) begin
        rowCnt_q <= '0;
        flag_q   <= ~flag_q;
      end else begin
        rowCnt_q <= rowCnt_q + RCW'(1);
      end
    end
  end

  assign issueDataflow = (accept && state_q == IDLE) ? cfg_dataflow : dataflow_q;

  for (genvar m = 0; m < MESHROWS; m++) begin : gRowMesh
    for (genvar t = 0; t < TILEROWS; t++) begin : gRowTile
      localparam int R = m * TILEROWS + t;
      logic [BITWIDTH-1:0] laneA;
      assign laneA = accept ? up.up_a[R*BITWIDTH +: BITWIDTH] : '0;
      skew_delay_line #(.WIDTH(BITWIDTH), .DEPTH(R + 1)) uSkewA (
        .clock (clock),
        .reset (reset),
        .data_i(laneA),
        .data_o(out_a[m][t])
      );
    end
  end

  for (genvar m = 0; m < MESHCOLUMNS; m++) begin : gColMesh
    for (genvar t = 0; t < TILECOLUMNS; t++) begin : gColTile
      localparam int C = m * TILECOLUMNS + t;
      logic [BITWIDTH-1:0] laneB, laneD;
      logic [CW-1:0]       colIn, colOut;
      assign laneB = accept ? up.up_b[C*BITWIDTH +: BITWIDTH] : '0;
      assign laneD = accept ? up.up_d[C*BITWIDTH +: BITWIDTH] : '0;
      assign colIn = {accept, flag_q, issueDataflow, laneD, laneB};
      skew_delay_line #(.WIDTH(CW), .DEPTH(C + 1)) uSkewCol (
        .clock (clock),
        .reset (reset),
        .data_i(colIn),
        .data_o(colOut)
      );
      assign out_b[m][t]         = colOut[BITWIDTH-1:0];
      assign out_d[m][t]         = colOut[2*BITWIDTH-1:BITWIDTH];
      assign out_dataflow[m][t]  = colOut[2*BITWIDTH];
      assign out_propagate[m][t] = colOut[2*BITWIDTH+1];
      assign out_valid[m][t]     = colOut[2*BITWIDTH+2];
    end
  end

endmodule

// File: tb/tb_sys_array_feeder.sv
// Bench for the systolic array feeder on a 2x2 mesh of 1x1 tiles.
module tb_sys_array_feeder;

  localparam int MR    = 2;
  localparam int MC    = 2;
  localparam int TR    = 1;
  localparam int TC    = 1;
  localparam int BW    = 8;
  localparam int ROWS  = MR * TR;
  localparam int COLS  = MC * TC;
  localparam int FLUSH = ROWS + COLS - 1;
  localparam int MAXC  = 1024;

  logic clock;
  logic reset;
  logic cfgDataflow;
  logic [MR-1:0][TR-1:0][BW-1:0] outA;
  logic [MC-1:0][TC-1:0][BW-1:0] outB, outD;
  logic [MC-1:0][TC-1:0]         outDataflow, outPropagate, outValid;
  logic busy, done;

  sys_array_feeder_if #(.ROWS(ROWS), .COLS(COLS), .BITWIDTH(BW)) upIf ();

  sys_array_feeder #(
    .MESHROWS(MR), .MESHCOLUMNS(MC), .TILEROWS(TR), .TILECOLUMNS(TC), .BITWIDTH(BW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_dataflow (cfgDataflow),
    .up           (upIf),
    .out_a        (outA),
    .out_b        (outB),
    .out_d        (outD),
    .out_dataflow (outDataflow),
    .out_propagate(outPropagate),
    .out_valid    (outValid),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: job status, bubbles still owed, beat index in matrix.
  bit mInJob;
  int mFlushLeft;
  int mRowIdx;
  bit mFlag;
  bit mDf;

  // What was issued into the skew in each cycle; lane r appears r+1 later.
  logic [BW-1:0] hA [MAXC][ROWS];
  logic [BW-1:0] hB [MAXC][COLS];
  logic [BW-1:0] hD [MAXC][COLS];
  bit hV [MAXC];
  bit hP [MAXC];
  bit hF [MAXC];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    mInJob = 0; mFlushLeft = 0; mRowIdx = 0; mFlag = 0; mDf = 0;
    for (int k = 0; k < MAXC; k++) begin
      for (int r = 0; r < ROWS; r++) hA[k][r] = '0;
      for (int c = 0; c < COLS; c++) begin hB[k][c] = '0; hD[k][c] = '0; end
      hV[k] = 0; hP[k] = 0; hF[k] = 0;
    end
  endtask

  task automatic checkCycle();
    int k;
    checkOutput($sformatf("up_ready@%0d", cyc), 32'(upIf.up_ready), 32'(mFlushLeft == 0));
    checkOutput($sformatf("busy@%0d", cyc), 32'(busy), 32'(mInJob));
    checkOutput($sformatf("done@%0d", cyc), 32'(done), 32'(mFlushLeft == 1));
    for (int r = 0; r < ROWS; r++) begin
      k = cyc - 1 - r;
      checkOutput($sformatf("out_a[%0d]@%0d", r, cyc), 32'(outA[r/TR][r%TR]),
                  (k >= 0) ? 32'(hA[k][r]) : 32'd0);
    end
    for (int c = 0; c < COLS; c++) begin
      k = cyc - 1 - c;
      checkOutput($sformatf("out_b[%0d]@%0d", c, cyc), 32'(outB[c/TC][c%TC]),
                  (k >= 0) ? 32'(hB[k][c]) : 32'd0);
      checkOutput($sformatf("out_d[%0d]@%0d", c, cyc), 32'(outD[c/TC][c%TC]),
                  (k >= 0) ? 32'(hD[k][c]) : 32'd0);
      checkOutput($sformatf("out_valid[%0d]@%0d", c, cyc), 32'(outValid[c/TC][c%TC]),
                  (k >= 0) ? 32'(hV[k]) : 32'd0);
      checkOutput($sformatf("out_propagate[%0d]@%0d", c, cyc), 32'(outPropagate[c/TC][c%TC]),
                  (k >= 0) ? 32'(hP[k]) : 32'd0);
      checkOutput($sformatf("out_dataflow[%0d]@%0d", c, cyc), 32'(outDataflow[c/TC][c%TC]),
                  (k >= 0) ? 32'(hF[k]) : 32'd0);
    end
  endtask

  // Drive one cycle of upstream inputs, check outputs, advance the model.
  task automatic applyStimulus(input bit v, input bit l, input bit cfg,
                               input logic [ROWS*BW-1:0] a,
                               input logic [COLS*BW-1:0] b,
                               input logic [COLS*BW-1:0] d);
    bit acc;
    upIf.up_valid = v;
    upIf.up_last  = l;
    upIf.up_a     = a;
    upIf.up_b     = b;
    upIf.up_d     = d;
    cfgDataflow   = cfg;
    @(negedge clock);
    checkCycle();
    acc = v && (mFlushLeft == 0);
    for (int r = 0; r < ROWS; r++) hA[cyc][r] = acc ? a[r*BW +: BW] : '0;
    for (int c = 0; c < COLS; c++) begin
      hB[cyc][c] = acc ? b[c*BW +: BW] : '0;
      hD[cyc][c] = acc ? d[c*BW +: BW] : '0;
    end
    hV[cyc] = acc;
    hP[cyc] = mFlag;
    hF[cyc] = (acc && !mInJob) ? cfg : mDf;
    if (mFlushLeft > 0) begin
      mFlushLeft--;
      if (mFlushLeft == 0) mInJob = 0;
    end
    if (acc) begin
      if (!mInJob) begin mInJob = 1; mDf = cfg; end
      mRowIdx++;
      if (l || mRowIdx == ROWS) begin mFlag = ~mFlag; mRowIdx = 0; end
      if (l) mFlushLeft = FLUSH;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic bubble();
    applyStimulus(0, 0, cfgDataflow, '0, '0, '0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    upIf.up_valid = 1'b0;
    upIf.up_last  = 1'b0;
    #1;
    @(posedge clock);
    #1;
    for (int r = 0; r < ROWS; r++)
      checkOutput($sformatf("reset out_a[%0d]", r), 32'(outA[r/TR][r%TR]), 32'd0);
    for (int c = 0; c < COLS; c++) begin
      checkOutput($sformatf("reset out_b[%0d]", c), 32'(outB[c/TC][c%TC]), 32'd0);
      checkOutput($sformatf("reset out_valid[%0d]", c), 32'(outValid[c/TC][c%TC]), 32'd0);
      checkOutput($sformatf("reset out_propagate[%0d]", c), 32'(outPropagate[c/TC][c%TC]), 32'd0);
    end
    checkOutput("reset up_ready", 32'(upIf.up_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    clearModel();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    bit expProp [4];
    bit v, l, cfg;
    expProp[0] = 0; expProp[1] = 0; expProp[2] = 1; expProp[3] = 1;
    reset = 1'b1;
    cfgDataflow = 1'b0;
    upIf.up_valid = 1'b0; upIf.up_last = 1'b0;
    upIf.up_a = '0; upIf.up_b = '0; upIf.up_d = '0;
    clearModel();
    doReset();

    // Single-beat job: lanes appear one cycle apart, done after the flush.
    applyStimulus(1, 1, 0, {8'd5, 8'd3}, {8'hFE, 8'd7}, {8'd1, 8'd1});
    checkOutput("single out_a0", 32'(outA[0][0]), 32'd3);
    checkOutput("single out_b0", 32'(outB[0][0]), 32'd7);
    checkOutput("single out_d0", 32'(outD[0][0]), 32'd1);
    checkOutput("single valid0", 32'(outValid[0][0]), 32'd1);
    checkOutput("single ready c1", 32'(upIf.up_ready), 32'd0);
    bubble();
    checkOutput("single out_a1", 32'(outA[1][0]), 32'd5);
    checkOutput("single out_b1", 32'(outB[1][0]), 32'hFE);
    checkOutput("single valid1", 32'(outValid[1][0]), 32'd1);
    bubble();
    checkOutput("single done c3", 32'(done), 32'd1);
    bubble();
    bubble();

    // Four beats: propagate flips after each full matrix and after last.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, i == 3, 0, 16'($urandom), 16'($urandom), 16'($urandom));
      checkOutput($sformatf("matrix prop beat%0d", i), 32'(outPropagate[0][0]), 32'(expProp[i]));
    end
    for (int i = 0; i < FLUSH; i++) bubble();
    applyStimulus(1, 1, 0, 16'($urandom), 16'($urandom), 16'($urandom));
    checkOutput("next job prop", 32'(outPropagate[0][0]), 32'd0);
    for (int i = 0; i < FLUSH + 1; i++) bubble();

    // Upstream stall between two beats.
    doReset();
    applyStimulus(1, 0, 0, 16'h0102, 16'h0304, 16'h0506);
    checkOutput("stall valid c1", 32'(outValid[0][0]), 32'd1);
    checkOutput("stall prop c1", 32'(outPropagate[0][0]), 32'd0);
    bubble();
    checkOutput("stall valid c2", 32'(outValid[0][0]), 32'd0);
    applyStimulus(1, 1, 0, 16'h0708, 16'h090A, 16'h0B0C);
    checkOutput("stall valid c3", 32'(outValid[0][0]), 32'd1);
    checkOutput("stall prop c3", 32'(outPropagate[0][0]), 32'd0);
    for (int i = 0; i < FLUSH; i++) bubble();

    // Dataflow is held from the first beat, then resampled next job.
    applyStimulus(1, 0, 1, 16'($urandom), 16'($urandom), 16'($urandom));
    checkOutput("df beat0", 32'(outDataflow[0][0]), 32'd1);
    applyStimulus(1, 0, 0, 16'($urandom), 16'($urandom), 16'($urandom));
    checkOutput("df beat1", 32'(outDataflow[0][0]), 32'd1);
    applyStimulus(1, 1, 0, 16'($urandom), 16'($urandom), 16'($urandom));
    checkOutput("df beat2", 32'(outDataflow[0][0]), 32'd1);
    for (int i = 0; i < FLUSH; i++) bubble();
    applyStimulus(1, 1, 0, 16'($urandom), 16'($urandom), 16'($urandom));
    checkOutput("df next job", 32'(outDataflow[0][0]), 32'd0);
    for (int i = 0; i < FLUSH; i++) bubble();

    // Backpressure: a beat held during flush is taken right after done.
    doReset();
    applyStimulus(1, 1, 0, 16'h1111, 16'h2222, 16'h3333);
    for (int i = 0; i < FLUSH; i++) begin
      applyStimulus(1, 1, 0, 16'h0055, 16'h0066, 16'h0077);
      checkOutput($sformatf("held not taken %0d", i), 32'(outValid[0][0]), 32'd0);
    end
    applyStimulus(1, 1, 0, 16'h0055, 16'h0066, 16'h0077);
    checkOutput("held taken valid", 32'(outValid[0][0]), 32'd1);
    checkOutput("held taken a0", 32'(outA[0][0]), 32'h55);

    // Reset during flush abandons the job without a done pulse.
    bubble();
    doReset();

    // Randomized traffic, with one reset dropped into the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      v   = ($urandom_range(0, 9) < 7);
      l   = ($urandom_range(0, 3) == 0);
      cfg = 1'($urandom_range(0, 1));
      applyStimulus(v, l, cfg, 16'($urandom), 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < FLUSH + 2; i++) bubble();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_array_feeder.md
Name: sys_array_feeder

Overview:
- Transmit-side front end for the systolic mesh. Accepts time-aligned beats from upstream over a valid/ready handshake: one A row-vector, one B row-vector, one D row-vector, plus a last flag.
- Skews each lane by its mesh position and drives the mesh west (a) and north (b, d, dataflow, propagate, valid) inputs.
- Generates the per-matrix propagate toggle itself. Flushes the mesh with bubbles after each job.

Parameters:
- MESHROWS, 4, tile rows in mesh.
- MESHCOLUMNS, 4, tile columns in mesh.
- TILEROWS, 1, PE rows per tile.
- TILECOLUMNS, 1, PE columns per tile.
- BITWIDTH, 8, signed element width.

Ports:
- clock  in  1  single clock; all logic posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- cfg_dataflow  in  1  dataflow bit; sampled at first accepted beat of a job.
- up_valid  in  1  upstream beat valid.
- up_ready  out  1  feeder can accept a beat.
- up_last  in  1  beat is last of job.
- up_a  in  ROWS*BITWIDTH  A vector; lane r = bits [r*BITWIDTH +: BITWIDTH].
- up_b  in  COLS*BITWIDTH  B vector, same packing.
- up_d  in  COLS*BITWIDTH  D (bias) vector, same packing.
- out_a  out  [MESHROWS][TILEROWS] x BITWIDTH  to mesh in_a.
- out_b, out_d  out  [MESHCOLUMNS][TILECOLUMNS] x BITWIDTH  to mesh in_b / in_d.
- out_dataflow, out_propagate, out_valid  out  [MESHCOLUMNS][TILECOLUMNS] x 1  to mesh.
- busy  out  1  job in progress (STREAM or FLUSH).
- done  out  1  one-cycle pulse at end of flush.

Behaviour:
- ROWS = MESHROWS*TILEROWS; COLS = MESHCOLUMNS*TILECOLUMNS.
- Flattened lane index: r = m*TILEROWS+t; c = m*TILECOLUMNS+t.
- FLUSH_CYCLES = ROWS+COLS-1.
- Reset (async): all outputs 0, state IDLE, propagate flag 0, counters 0, skew registers 0.
- FSM states: IDLE, STREAM, FLUSH.
  - IDLE: up_ready=1. On an accepted beat (up_valid & up_ready), latch cfg_dataflow and go to STREAM. If up_last is also set on that beat, go directly to FLUSH.
  - STREAM: up_ready=1. Accepted beat with up_last=1 -> FLUSH.
  - FLUSH: up_ready=0. flush_cnt counts 0..FLUSH_CYCLES-1. At the last count, pulse done=1 for one cycle and go to IDLE.
- busy = (state != IDLE).
- A beat issued in a cycle = accepted beat. A cycle without one issues a bubble: data lanes 0, valid 0. Propagate holds its current value and dataflow holds the latched value.
- Skew:
  - A lane r is delayed r+1 cycles from acceptance.
  - B, D, dataflow, propagate and valid lane c are delayed c+1 cycles.
  - Lane 0 is therefore one register stage. All outputs are registered, with no combinational path from up_* to out_*.
- Propagate generation:
  - row_cnt counts accepted beats 0..ROWS-1 and wraps.
  - Beats within one matrix carry the current flag.
  - When the beat with row_cnt==ROWS-1 is accepted, the flag toggles for the next beat.
  - up_last resets row_cnt to 0 and also toggles the flag, so a partial final matrix still closes its buffer.
  - The flag persists across jobs; only reset clears it.
- Upstream stall (up_valid=0 in STREAM): insert a bubble. row_cnt and flag do not advance.
- Arithmetic: none. Data pass unmodified (signed, BITWIDTH bits).
- Reset mid-operation: immediate abandonment. No done pulse. Skew contents are discarded (outputs go to 0).
- cfg_dataflow changes mid-job: ignored until the next job's first beat.

Decomposition:
- Shared package sys_array_pkg holds:
  - feeder_state_t enum {IDLE, STREAM, FLUSH};
  - functions rows_f(MESHROWS,TILEROWS), cols_f(MESHCOLUMNS,TILECOLUMNS) and flush_cycles_f.
- One sub-module, skew_delay_line: parameters WIDTH and DEPTH (>=1). Shift register with async active-high reset to 0.
  - Instantiated once per A lane (WIDTH=BITWIDTH, DEPTH=r+1).
  - Instantiated once per column lane (WIDTH=2*BITWIDTH+3, DEPTH=c+1).

Test Plan:
- Reset release, mesh 2x2, tiles 1x1: all outputs 0, up_ready=1, busy=0. Assert reset mid-FLUSH -> outputs 0 next edge, no done.
- Single beat a={3,5}, b={7,-2}, d={1,1}, last=1 at cycle 0:
  - out_a[0]=3 and out_b[0]=7, out_d[0]=1, out_valid[0]=1 at cycle 1;
  - out_a[1]=5 and out_b[1]=-2, out_valid[1]=1 at cycle 2;
  - up_ready=0 for cycles 1..3; done pulses at cycle 3.
- Four back-to-back beats, last on the 4th, mesh 2x2: lane-0 propagate reads 0,0,1,1 on cycles 1-4. Flag is 0 at the start of the next job.
- Upstream stall: beats at cycles 0 and 2, none at 1 -> out_valid[0] sequence 1,0,1. The propagate of both beats is equal (row_cnt does not advance on the bubble).
- Dataflow latch: cfg_dataflow=1 at the first beat, changed to 0 mid-job -> all out_dataflow lanes read 1 for the whole job. The next job samples the new value.
- Backpressure: up_valid=1 held during FLUSH with up_ready=0 -> no beat consumed. The held beat is accepted in the cycle after done.
